// File: rtl/tensor_dispatch.sv
// Issue-side sequencer for the tensor unit: reads per-step A/B/C operands for one
// request and streams them to a thread group through a 2-entry skid FIFO.
module tensor_dispatch #(
    parameter int  THREAD_GROUP_SIZE = 4,
    parameter int  XLEN              = 32,
    parameter int  MAX_STEPS         = 8,
    localparam int SW                = $clog2(MAX_STEPS),
    localparam int RW                = $clog2(XLEN),
    localparam int AW                = THREAD_GROUP_SIZE * XLEN,
    localparam int BW                = THREAD_GROUP_SIZE * AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wb,
    input  logic [RW-1:0] req_rd,
    input  logic          req_fmt_in,
    input  logic          req_fmt_out,
    input  logic [SW-1:0] req_steps,
    output logic          rf_rd_en,
    output logic [SW-1:0] rf_rd_step,
    input  logic [AW-1:0] rf_a,
    input  logic [BW-1:0] rf_b,
    input  logic [AW-1:0] rf_c,
    output logic          tg_valid,
    input  logic          tg_ready,
    output logic [AW-1:0] tg_vec_a,
    output logic [BW-1:0] tg_vec_b,
    output logic [AW-1:0] tg_vec_c,
    output logic          tg_wb,
    output logic [RW-1:0] tg_rd,
    output logic          tg_fmt_in,
    output logic          tg_fmt_out,
    output logic [SW-1:0] tg_step,
    output logic          tg_last,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t        r_state, w_state_nxt;

    logic          r_wb, r_fmt_in, r_fmt_out;
    logic [RW-1:0] r_rd;
    logic [SW-1:0] r_steps;
    logic [SW-1:0] r_rd_ptr;
    logic          r_inflight;
    logic [SW-1:0] r_inflight_step;

    logic          r_head, r_tail;
    logic [1:0]    r_count;
    logic [AW-1:0] r_fa [2];
    logic [BW-1:0] r_fb [2];
    logic [AW-1:0] r_fc [2];
    logic [SW-1:0] r_fs [2];

    logic          w_valid, w_pop, w_push, w_credit, w_accept, w_last_pop;
    logic [2:0]    w_occ;

    assign w_valid    = (r_count != 2'd0);
    assign w_pop      = w_valid && tg_ready;
    assign w_push     = r_inflight;
    assign w_last_pop = w_pop && (r_fs[r_head] == r_steps);
    assign w_accept   = req_valid && req_ready;
    // Occupancy counts the read already on its way so the FIFO can never overflow.
    assign w_occ      = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_credit   = (w_occ < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rf_rd_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_READ;
            end
            S_READ: begin
                if (w_credit) begin
                    rf_rd_en = 1'b1;
                    if (r_rd_ptr == r_steps) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rf_rd_step = r_rd_ptr;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb            <= 1'b0;
            r_rd            <= '0;
            r_fmt_in        <= 1'b0;
            r_fmt_out       <= 1'b0;
            r_steps         <= '0;
            r_rd_ptr        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_step <= '0;
            r_head          <= 1'b0;
            r_tail          <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            if (w_accept) begin
                r_wb      <= req_wb;
                r_rd      <= req_rd;
                r_fmt_in  <= req_fmt_in;
                r_fmt_out <= req_fmt_out;
                r_steps   <= req_steps;
                r_rd_ptr  <= '0;
            end else if (rf_rd_en && (r_rd_ptr != r_steps)) begin
                r_rd_ptr <= r_rd_ptr + SW'(1);
            end
            r_inflight      <= rf_rd_en;
            r_inflight_step <= r_rd_ptr;
            if (w_push) r_tail <= ~r_tail;
            if (w_pop)  r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Operand storage carries no reset; outputs are masked by tg_valid instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa[r_tail] <= rf_a;
            r_fb[r_tail] <= rf_b;
            r_fc[r_tail] <= rf_c;
            r_fs[r_tail] <= r_inflight_step;
        end
    end

    assign tg_valid   = w_valid;
    assign tg_vec_a   = w_valid ? r_fa[r_head] : '0;
    assign tg_vec_b   = w_valid ? r_fb[r_head] : '0;
    assign tg_vec_c   = w_valid ? r_fc[r_head] : '0;
    assign tg_step    = w_valid ? r_fs[r_head] : '0;
    assign tg_last    = w_valid && (r_fs[r_head] == r_steps);
    assign tg_wb      = w_valid && r_wb;
    assign tg_rd      = w_valid ? r_rd : '0;
    assign tg_fmt_in  = w_valid && r_fmt_in;
    assign tg_fmt_out = w_valid && r_fmt_out;

endmodule

// File: tb/tb_tensor_dispatch.sv
// Scoreboard bench for tensor_dispatch: accepted requests queue expected beats,
// a monitor pops and compares every thread-group handshake.
module tb_tensor_dispatch;

    localparam int SW = 3;
    localparam int RW = 5;
    localparam int AW = 128;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_wb, req_fmt_in, req_fmt_out;
    logic [RW-1:0] req_rd;
    logic [SW-1:0] req_steps;
    logic          rf_rd_en;
    logic [SW-1:0] rf_rd_step;
    logic [AW-1:0] rf_a, rf_c;
    logic [BW-1:0] rf_b;
    logic          tg_valid, tg_ready;
    logic [AW-1:0] tg_vec_a, tg_vec_c;
    logic [BW-1:0] tg_vec_b;
    logic          tg_wb, tg_fmt_in, tg_fmt_out, tg_last, busy;
    logic [RW-1:0] tg_rd;
    logic [SW-1:0] tg_step;

    tensor_dispatch #(.THREAD_GROUP_SIZE(4), .XLEN(32), .MAX_STEPS(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb), .req_rd(req_rd),
        .req_fmt_in(req_fmt_in), .req_fmt_out(req_fmt_out), .req_steps(req_steps),
        .rf_rd_en(rf_rd_en), .rf_rd_step(rf_rd_step), .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c),
        .tg_valid(tg_valid), .tg_ready(tg_ready), .tg_vec_a(tg_vec_a), .tg_vec_b(tg_vec_b),
        .tg_vec_c(tg_vec_c), .tg_wb(tg_wb), .tg_rd(tg_rd), .tg_fmt_in(tg_fmt_in),
        .tg_fmt_out(tg_fmt_out), .tg_step(tg_step), .tg_last(tg_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step; bit last; int rd; bit wb; bit fi; bit fo; int id;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    cur_id   = 0;
    int    nreads   = 0;
    int    exp_reads = 0;
    logic  en_s = 1'b0;
    logic [SW-1:0] step_s = '0;
    logic  rand_mode = 1'b0;
    logic  tg_ready_dir = 1'b0;
    logic  hold_v = 1'b0;
    logic [511:0] hold_snap = '0;

    function automatic logic [AW-1:0] fa(input int st);
        return AW'(st * 'h11);
    endfunction
    function automatic logic [BW-1:0] fb(input int id, input int st);
        return BW'((id << 8) | st);
    endfunction
    function automatic logic [AW-1:0] fc(input int st);
        return {32'hC0DE0000 + 32'(st), 96'h0};
    endfunction

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Operand read port model: one-cycle latency, garbage when no read was issued.
    always @(posedge clk) begin
        #1;
        if (en_s) begin
            rf_a = fa(int'(step_s));
            rf_b = fb(cur_id, int'(step_s));
            rf_c = fc(int'(step_s));
        end else begin
            rf_a = '1;
            rf_b = '1;
            rf_c = '1;
        end
    end

    always @(posedge clk) begin
        #1;
        tg_ready = rand_mode ? 1'($urandom_range(0, 1)) : tg_ready_dir;
    end

    // Acceptance side: capture reads and queue the expected beats of each accepted request.
    always @(negedge clk) begin
        en_s   = rf_rd_en && !reset;
        step_s = rf_rd_step;
        if (!reset && rf_rd_en) nreads++;
        if (!reset && req_valid && req_ready) begin
            beat_t e;
            cur_id++;
            nreads    = 0;
            exp_reads = int'(req_steps) + 1;
            for (int s = 0; s <= int'(req_steps); s++) begin
                e.step = s; e.last = (s == int'(req_steps)); e.rd = int'(req_rd);
                e.wb = req_wb; e.fi = req_fmt_in; e.fo = req_fmt_out; e.id = cur_id;
                q.push_back(e);
            end
        end
    end

    // Monitor: compare each handshake against the queue head and check hold stability.
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold", 512'({tg_valid, tg_step, tg_last, tg_wb, tg_rd, tg_vec_a, tg_vec_c[127:96]}), hold_snap);
            if (tg_valid && !tg_ready) begin
                hold_v    = 1'b1;
                hold_snap = 512'({tg_valid, tg_step, tg_last, tg_wb, tg_rd, tg_vec_a, tg_vec_c[127:96]});
            end else begin
                hold_v = 1'b0;
            end
            if (tg_valid && tg_ready) begin
                chk("beat_expected", 512'(q.size() != 0), 512'(1));
                if (q.size() != 0) begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat_hdr", 512'({tg_step, tg_last, tg_wb, tg_rd, tg_fmt_in, tg_fmt_out}),
                        512'({SW'(e.step), e.last, e.wb, RW'(e.rd), e.fi, e.fo}));
                    chk("beat_a", 512'(tg_vec_a), 512'(fa(e.step)));
                    chk("beat_b", tg_vec_b, fb(e.id, e.step));
                    chk("beat_c", 512'(tg_vec_c), 512'(fc(e.step)));
                end
            end
        end
    end

    task automatic do_req(input int steps, input int rd, input bit wb, input bit fi, input bit fo);
        @(posedge clk); #1;
        req_valid = 1'b1; req_steps = SW'(steps); req_rd = RW'(rd);
        req_wb = wb; req_fmt_in = fi; req_fmt_out = fo;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("req_accept", 512'(req_ready), 512'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", 512'(busy), 512'(0));
        chk("sb_drained_at_idle", 512'(q.size()), 512'(0));
        chk("read_count", 512'(nreads), 512'(exp_reads));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_rd = '0;
        req_fmt_in = 1'b0; req_fmt_out = 1'b0; req_steps = '0;
        tg_ready = 1'b0; rf_a = '0; rf_b = '0; rf_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 512'(req_ready), 512'(1));
        chk("rst_tg_valid", 512'(tg_valid), 512'(0));
        chk("rst_rf_rd_en", 512'(rf_rd_en), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_tg_last", 512'(tg_last), 512'(0));
        chk("rst_outputs", 512'({tg_step, tg_rd, tg_wb, tg_fmt_in, tg_fmt_out, tg_vec_a, tg_vec_c}), 512'(0));
        chk("rst_vec_b", tg_vec_b, 512'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        tg_ready_dir = 1'b1;
        repeat (2) @(posedge clk);

        // Single beat with accept-to-beat latency
        do_req(0, 5, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_rd_en", 512'({rf_rd_en, rf_rd_step, busy, req_ready}), 512'({1'b1, 3'd0, 1'b1, 1'b0}));
        @(negedge clk);
        chk("t1_inflight", 512'({tg_valid, rf_rd_en}), 512'(0));
        @(negedge clk);
        chk("t1_beat", 512'({tg_valid, tg_last, tg_rd, tg_wb}), 512'({1'b1, 1'b1, 5'd5, 1'b1}));
        @(negedge clk);
        chk("t1_ready_again", 512'({req_ready, busy}), 512'({1'b1, 1'b0}));
        wait_idle();

        // Full rate, 8 beats
        do_req(7, 3, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 3) chk("t2_first_a", 512'({tg_valid, tg_vec_a}), 512'({1'b1, 128'h00}));
            if (i == 4) chk("t2_second_a", 512'({tg_valid, tg_vec_a}), 512'({1'b1, 128'h11}));
            if (i == 10) chk("t2_last_beat", 512'({tg_valid, tg_last, tg_step, tg_vec_a}), 512'({1'b1, 1'b1, 3'd7, 128'h77}));
            if (i == 11) chk("t2_done", 512'({busy, req_ready}), 512'({1'b0, 1'b1}));
        end
        wait_idle();

        // Backpressure: thread group stalls for 10 cycles after first beat
        tg_ready_dir = 1'b0;
        do_req(7, 17, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tg_valid) break;
        end
        chk("t3_first_valid", 512'(tg_valid), 512'(1));
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            chk("t3_stall", 512'({tg_valid, rf_rd_en, tg_step}), 512'({1'b1, 1'b0, 3'd0}));
        end
        tg_ready_dir = 1'b1;
        wait_idle();

        // Reset in the middle of an 8-beat request with a read in flight
        do_req(7, 9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tg_valid && tg_step == 3'd3) break;
        end
        chk("t4_at_step3", 512'({tg_valid, tg_step, rf_rd_en}), 512'({1'b1, 3'd3, 1'b1}));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t4_rst_state", 512'({tg_valid, req_ready, busy, rf_rd_en}), 512'({1'b0, 1'b1, 1'b0, 1'b0}));
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(1, 12, 1'b1, 1'b0, 1'b1);
        wait_idle();

        // Request offered during DRAIN is held until the current request finishes
        do_req(3, 7, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b1; req_steps = 3'd1; req_rd = 5'd9; req_wb = 1'b0;
        req_fmt_in = 1'b0; req_fmt_out = 1'b0;
        @(negedge clk);
        chk("t5_drain_blocked", 512'({req_ready, busy, rf_rd_en}), 512'({1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        chk("t5_last_fields", 512'({req_ready, tg_valid, tg_last, tg_rd, tg_wb}), 512'({1'b0, 1'b1, 1'b1, 5'd7, 1'b1}));
        @(negedge clk);
        chk("t5_held_accept", 512'(req_ready), 512'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();

        // Random backpressure over many requests
        rand_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle();
        end
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/tensor_dispatch.md
# tensor_dispatch

Issue-side sequencer for the tensor unit: accepts one matrix-multiply step request, reads the per-step A/B/C operand vectors from the tile operand read port, and streams them beat by beat into one thread group over a valid/ready handshake. Each beat carries the writeback tag (`wb`, `rd`) and the formats. It sits between tensor instruction decode and a `thread_group` input port. It absorbs thread-group backpressure with a 2-entry skid FIFO, so the operand read port never has to stall mid-read.

## Interface
- `THREAD_GROUP_SIZE`, 4, number of lanes per thread group.
- `XLEN`, 32, element width in bits.
- `MAX_STEPS`, 8, maximum beats per request; must be a power of 2 and at least 2.
- `SW = $clog2(MAX_STEPS)`, derived, width of the step index.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_wb` in 1: writeback is tile-local.
- `req_rd` in `$clog2(XLEN)`: destination tag.
- `req_fmt_in` in 1, `req_fmt_out` in 1: operand and result formats.
- `req_steps` in SW: beat count minus 1, so 0 means 1 beat.
- `rf_rd_en` out 1: operand read strobe.
- `rf_rd_step` out SW: step index being read.
- `rf_a` in `THREAD_GROUP_SIZE*XLEN`: A operand, valid the cycle after `rf_rd_en`.
- `rf_b` in `THREAD_GROUP_SIZE*THREAD_GROUP_SIZE*XLEN`: B operand, same timing as `rf_a`.
- `rf_c` in `THREAD_GROUP_SIZE*XLEN`: C operand, same timing as `rf_a`.
- `tg_valid` out 1: beat offered to the thread group.
- `tg_ready` in 1: thread group accepts the beat.
- `tg_vec_a`, `tg_vec_b`, `tg_vec_c` out, same widths as `rf_a`, `rf_b`, `rf_c`: beat operands.
- `tg_wb`, `tg_rd`, `tg_fmt_in`, `tg_fmt_out` out: request fields latched at acceptance.
- `tg_step` out SW: index of the beat.
- `tg_last` out 1: final beat of the request.
- `busy` out 1: a request is in progress.

## Operation
- FSM states are IDLE, READ, and DRAIN.
  - IDLE: `req_ready=1`. On handshake, latch the request fields, clear `rd_ptr`/`issued`, and go to READ.
  - READ: issue reads for steps 0..`req_steps` in order. After issuing step `req_steps`, go to DRAIN.
  - DRAIN: no reads. When the beat with `tg_last` completes its handshake, go to IDLE.
- Read credit rule:
  - Issue `rf_rd_en` in a cycle only if `fifo_count + inflight - pop < 2`.
  - `inflight` is 1 if a read was issued in the previous cycle.
  - `pop` is `tg_valid && tg_ready`.
  - This guarantees the FIFO never overflows.
- Read data, tagged with its step index, is pushed into the 2-entry FIFO in the cycle it arrives.
- `tg_*` outputs are driven from the FIFO head. `tg_valid = fifo_count != 0`.
- `tg_last = (tg_step == latched req_steps)`.
- While `tg_valid && !tg_ready`, every `tg_*` output holds stable.
- `busy = (state != IDLE)`.
- Step index arithmetic is unsigned SW bits. The read pointer stops at `req_steps` and never wraps.
- Reset, whether idle or mid-request:
  - Go to IDLE; FIFO empty; in-flight read discarded (its data is not pushed after reset deasserts).
  - Reset values: `req_ready=1`; `tg_valid=0`, `rf_rd_en=0`, `busy=0`, `tg_last=0`; all data/tag outputs 0.

## Timing
- Request handshake at edge E0 → `rf_rd_en` with step 0 in the cycle after E0.
- Data pushed at the following edge → `tg_valid=1` two cycles after E0, i.e. 3 cycles accept-to-beat counting the accept cycle.
- Throughput: with `tg_ready` held high, 1 beat per cycle. An N-beat request finishes its last handshake N+2 cycles after E0.
- `req_ready` rises in the cycle after the last-beat handshake. There is no back-to-back overlap with the next request.
- A `req_valid` seen while not in IDLE is ignored; `req_ready=0` there.
- A push and a pop in the same cycle leave `fifo_count` unchanged. The FIFO head advances in order.
- `tg_ready` low for any length of time: at most 2 buffered beats plus 0 in-flight reads. `rf_rd_en` stays low until a pop frees a credit.

## Test plan
- Single beat: `req_steps=0`, `rd=5`, `wb=1`, `tg_ready=1` → one `rf_rd_en` (step 0). One beat with `tg_last=1`, `tg_rd=5`, `tg_wb=1`, 2 cycles after accept. `req_ready=1` again the next cycle.
- Full rate: `req_steps=7`, `tg_ready=1`, `rf_a=step*0x11` → 8 consecutive beats, steps 0..7. `tg_vec_a` equals 0x00..0x77. `tg_last` set only on step 7.
- Backpressure: `req_steps=7`, `tg_ready=0` for 10 cycles after the first `tg_valid` → exactly 2 reads outstanding/buffered, `rf_rd_en` low, outputs stable. After release, all 8 beats arrive in order with none lost or duplicated.
- Random `tg_ready` at 50% over 200 requests with random `req_steps` → the beat sequence per request is complete and in order. `busy` deasserts only after the `tg_last` handshake.
- Reset mid-request: assert `reset` during step 3 of an 8-beat request with a read in flight → next cycle `tg_valid=0`, `req_ready=1`, `busy=0`. A new `req_steps=1` request then yields exactly steps 0 and 1.
- Request while busy: pulse `req_valid` during DRAIN → not accepted, latched fields unchanged. The held request is accepted on the cycle after the last beat.
